// File: rtl/lane_rotate_engine.sv
// rtl/lane_rotate_engine.sv - per-lane Keccak rho rotation across DEPTH slices (optional ROT_INVERSE_EN adds dir)
// Loads DEPTH 25-bit slices, then streams each rotated slice out once.
module lane_rotate_engine #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef ROT_INVERSE_EN
    input  logic          dir,
`endif
    output logic [AW-1:0] rd_addr,
    input  logic [24:0]   rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [24:0]   wr_data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam int unsigned ROT [25] = '{
        0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
        25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14
    };

    state_t        state;
    logic [AW-1:0] cnt;
    logic [24:0]   buffer [DEPTH];
    logic [24:0]   rot_bits;
`ifdef ROT_INVERSE_EN
    logic          dir_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wr_en <= 1'b0;
`ifdef ROT_INVERSE_EN
            dir_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef ROT_INVERSE_EN
                        dir_q <= dir;
`endif
                    end
                end
                S_LOAD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_STORE;
                        cnt   <= '0;
                        wr_en <= 1'b1;
                    end
                end
                S_STORE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Buffer is deliberately unreset; only LOAD may write it.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            buffer[cnt] <= rd_data;
        end
    end

    // Each lane reads its own bit column at an offset slice; AW-bit math wraps mod DEPTH.
    for (genvar i = 0; i < 25; i++) begin : g_lane
        localparam logic [AW-1:0] R = AW'(ROT[i] % DEPTH);
        logic [AW-1:0] src;
`ifdef ROT_INVERSE_EN
        assign src = dir_q ? cnt + R : cnt - R;
`else
        assign src = cnt - R;
`endif
        assign rot_bits[i] = buffer[src][i];
    end

    assign rd_addr = (state == S_LOAD) ? cnt : '0;
    assign wr_addr = wr_en ? cnt : '0;
    assign wr_data = wr_en ? rot_bits : '0;

endmodule
